gbm_path_scheduler: RTL and testbench



---
 rtl/fpga_cfg_pkg.sv | 21 ++
 rtl/gbm_path_scheduler_if.sv | 30 +++
 rtl/gbm_path_store.sv | 27 ++
 rtl/gbm_path_scheduler.sv | 169 ++++++++++++++++
 tb/tb_gbm_path_scheduler.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fpga_cfg_pkg.sv
// Shared fixed-point configuration and GBM path-scheduler types.
// The word format is Q15.16 signed, held in FP_WIDTH bits.
package fpga_cfg_pkg;

  localparam int FP_WIDTH      = 32;
  localparam int GBM_NUM_PATHS = 64;
  localparam int GBM_NUM_STEPS = 50;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } gbm_sched_state_t;

  // Index width for a counter over n entries; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gbm_path_scheduler_if.sv
// Sample/result handshake between the path scheduler (master) and one GBM
// step lane (slave).
interface gbm_path_scheduler_if
  import fpga_cfg_pkg::*;
#(
  parameter int WIDTH = FP_WIDTH
);

  logic                    gbm_valid_out;
  logic                    gbm_ready_in;
  logic signed [WIDTH-1:0] gbm_z;
  logic        [WIDTH-1:0] gbm_s;
  logic        [WIDTH-1:0] gbm_r;
  logic        [WIDTH-1:0] gbm_sigma;
  logic        [WIDTH-1:0] gbm_dt;
  logic                    gbm_valid_in;
  logic                    gbm_ready_out;
  logic        [WIDTH-1:0] gbm_s_next;

  modport master (
    output gbm_valid_out, gbm_z, gbm_s, gbm_r, gbm_sigma, gbm_dt, gbm_ready_out,
    input  gbm_ready_in, gbm_valid_in, gbm_s_next
  );

  modport slave (
    input  gbm_valid_out, gbm_z, gbm_s, gbm_r, gbm_sigma, gbm_dt, gbm_ready_out,
    output gbm_ready_in, gbm_valid_in, gbm_s_next
  );

endinterface

// File: rtl/gbm_path_store.sv
// Per-path price register file: asynchronous read, synchronous write.
// Contents are not reset; every entry is written before it is read in a run.
module gbm_path_store
  import fpga_cfg_pkg::*;
#(
  parameter int WIDTH = FP_WIDTH,
  parameter int DEPTH = GBM_NUM_PATHS
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [idx_w(DEPTH)-1:0]   waddr,
  input  logic [WIDTH-1:0]          wdata,
  input  logic [idx_w(DEPTH)-1:0]   raddr,
  output logic [WIDTH-1:0]          rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/gbm_path_scheduler.sv
// Walks NUM_PATHS paths through NUM_STEPS steps of one GBM lane, keeping path
// prices locally. Define GBM_SCHED_STREAM_EN to forward tagged results on out_*.
module gbm_path_scheduler
  import fpga_cfg_pkg::*;
#(
  parameter int WIDTH     = FP_WIDTH,
  parameter int NUM_PATHS = GBM_NUM_PATHS,
  parameter int NUM_STEPS = GBM_NUM_STEPS
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic        [WIDTH-1:0]       cfg_s0,
  input  logic        [WIDTH-1:0]       cfg_r,
  input  logic        [WIDTH-1:0]       cfg_sigma,
  input  logic        [WIDTH-1:0]       cfg_dt,
  input  logic                          z_valid,
  output logic                          z_ready,
  input  logic signed [WIDTH-1:0]       z,
  gbm_path_scheduler_if.master          lane,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic        [WIDTH-1:0]       out_s,
  output logic [idx_w(NUM_PATHS)-1:0]   out_path,
  output logic [idx_w(NUM_STEPS)-1:0]   out_step,
  output logic                          busy,
  output logic                          done,
  output logic                          err_unexpected
);

  localparam int PW = idx_w(NUM_PATHS);
  localparam int SW = idx_w(NUM_STEPS);
  localparam int OW = $clog2(NUM_PATHS + 1);
  localparam logic [PW-1:0] LAST_PATH = PW'(NUM_PATHS - 1);
  localparam logic [SW-1:0] LAST_STEP = SW'(NUM_STEPS - 1);

  gbm_sched_state_t state_q, state_d;

  logic [PW-1:0]    issue_path_q;
  logic [PW-1:0]    retire_path_q;
  logic [SW-1:0]    step_q;
  logic [OW-1:0]    outstanding_q;
  logic             err_q;
  logic [WIDTH-1:0] s0_q, r_q, sigma_q, dt_q;
  logic [WIDTH-1:0] store_rdata;

  logic in_issue;
  logic accept_start;
  logic issue_fire;
  logic retire_fire;
  logic res_expected;

  assign in_issue     = (state_q == ST_ISSUE);
  assign accept_start = (state_q == ST_IDLE) && start;
  assign res_expected = (outstanding_q != '0);
  assign issue_fire   = in_issue && z_valid && lane.gbm_ready_in;

`ifdef GBM_SCHED_STREAM_EN
  // A result with nothing outstanding is swallowed here so it never reaches
  // the regression stage or stalls the lane.
  assign lane.gbm_ready_out = res_expected ? out_ready : lane.gbm_valid_in;
  assign out_valid          = lane.gbm_valid_in && res_expected;
`else
  logic unused_out_ready;
  assign unused_out_ready   = out_ready;
  assign lane.gbm_ready_out = 1'b1;
  assign out_valid          = 1'b0;
`endif

  assign retire_fire = lane.gbm_valid_in && lane.gbm_ready_out && res_expected;

  assign out_s    = out_valid ? lane.gbm_s_next : '0;
  assign out_path = retire_path_q;
  assign out_step = step_q;
  assign err_unexpected = err_q;

  // Sample fields are forced to zero outside ISSUE so idle outputs read 0.
  assign z_ready            = issue_fire;
  assign lane.gbm_valid_out = in_issue && z_valid;
  assign lane.gbm_z         = in_issue ? z : '0;
  assign lane.gbm_s         = !in_issue ? '0 : ((step_q == '0) ? s0_q : store_rdata);
  assign lane.gbm_r         = in_issue ? r_q : '0;
  assign lane.gbm_sigma     = in_issue ? sigma_q : '0;
  assign lane.gbm_dt        = in_issue ? dt_q : '0;

  gbm_path_store #(
    .WIDTH (WIDTH),
    .DEPTH (NUM_PATHS)
  ) u_store (
    .clk   (clk),
    .we    (retire_fire),
    .waddr (retire_path_q),
    .wdata (lane.gbm_s_next),
    .raddr (issue_path_q),
    .rdata (store_rdata)
  );

  always_comb begin
    state_d = state_q;
    busy    = (state_q != ST_IDLE);
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (issue_fire && (issue_path_q == LAST_PATH)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Step barrier: the next step opens only after its last path retires.
        if (retire_fire && (retire_path_q == LAST_PATH)) begin
          state_d = (step_q == LAST_STEP) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      issue_path_q  <= '0;
      retire_path_q <= '0;
      step_q        <= '0;
      outstanding_q <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept_start) begin
        issue_path_q  <= '0;
        retire_path_q <= '0;
        step_q        <= '0;
        outstanding_q <= '0;
      end else begin
        if (issue_fire) begin
          issue_path_q <= (issue_path_q == LAST_PATH) ? '0 : issue_path_q + 1'b1;
        end
        if (retire_fire) begin
          retire_path_q <= (retire_path_q == LAST_PATH) ? '0 : retire_path_q + 1'b1;
        end
        if ((state_q == ST_DRAIN) && (state_d == ST_ISSUE)) begin
          step_q <= step_q + 1'b1;
        end
        case ({issue_fire, retire_fire})
          2'b10:   outstanding_q <= outstanding_q + 1'b1;
          2'b01:   outstanding_q <= outstanding_q - 1'b1;
          default: outstanding_q <= outstanding_q;
        endcase
      end
      if (lane.gbm_valid_in && !res_expected) begin
        err_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept_start) begin
      s0_q    <= cfg_s0;
      r_q     <= cfg_r;
      sigma_q <= cfg_sigma;
      dt_q    <= cfg_dt;
    end
  end

endmodule

// File: tb/tb_gbm_path_scheduler.sv
// Directed bench for gbm_path_scheduler with a behavioural in-order lane
// (echo or +1.0) on a 4-path, 3-step configuration.
module tb_gbm_path_scheduler;
  import fpga_cfg_pkg::*;

  localparam int W  = 32;
  localparam int NP = 4;
  localparam int NS = 3;
  localparam logic [W-1:0] ONE = 32'h0001_0000;

  typedef struct {
    logic [W-1:0] s0;
    bit           add_one;
    bit           zgap;
    bit           rgap;
    bit           ogap;
    bit           poke;
    bit           stall;
    logic [W-1:0] exp_iss;
    logic [W-1:0] exp_final;
  } run_vec_t;

  logic clk = 1'b0;
  logic rst_n, start;
  logic [W-1:0] cfg_s0, cfg_r, cfg_sigma, cfg_dt;
  logic z_valid, z_ready;
  logic signed [W-1:0] z;
  logic out_valid, out_ready;
  logic [W-1:0] out_s;
  logic [1:0] out_path, out_step;
  logic busy, done, err_unexpected;

  gbm_path_scheduler_if #(.WIDTH(W)) lif ();

  gbm_path_scheduler #(.WIDTH(W), .NUM_PATHS(NP), .NUM_STEPS(NS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cfg_s0(cfg_s0), .cfg_r(cfg_r), .cfg_sigma(cfg_sigma), .cfg_dt(cfg_dt),
    .z_valid(z_valid), .z_ready(z_ready), .z(z),
    .lane(lif),
    .out_valid(out_valid), .out_ready(out_ready), .out_s(out_s),
    .out_path(out_path), .out_step(out_step),
    .busy(busy), .done(done), .err_unexpected(err_unexpected)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0, cyc = 0;
  logic [W-1:0] lane_q[$];
  bit lane_en = 1'b1, force_spur = 1'b0, add_one = 1'b0;
  bit zgap = 1'b0, rgap = 1'b0, ogap = 1'b0, out_hold = 1'b0;
  logic [W-1:0] cur_s0, cur_r, cur_sig, cur_dt;
  logic [W-1:0] m_store[NP], last_iss[NP], last_out[NP];
  int m_ipath, m_istep, m_rpath, m_rstep;
  int n_issue, n_zr, ret_cnt, done_cnt, last_ret_cyc;
  run_vec_t vec[5];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Source and downstream stimulus, updated 2 time units after each edge.
  initial begin
    forever begin
      z_valid = zgap ? 1'($urandom_range(0, 1)) : 1'b1;
      z       = $urandom;
      lif.gbm_ready_in = rgap ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready = out_hold ? 1'b0 : (ogap ? 1'($urandom_range(0, 1)) : 1'b1);
      @(posedge clk); #2;
    end
  end

  // Behavioural lane: returns queued results in order, one cycle after issue at the earliest.
  initial begin
    lif.gbm_valid_in = 1'b0;
    lif.gbm_s_next   = '0;
    forever begin
      @(posedge clk); #3;
      if (force_spur) begin
        lif.gbm_valid_in = 1'b1;
        lif.gbm_s_next   = 32'hDEAD_0000;
      end else if (lane_en && lane_q.size() > 0) begin
        lif.gbm_valid_in = 1'b1;
        lif.gbm_s_next   = lane_q[0];
      end else begin
        lif.gbm_valid_in = 1'b0;
        lif.gbm_s_next   = '0;
      end
    end
  end

  // Monitor: values seen at the falling edge are the ones the next rising edge captures.
  initial begin
    logic [W-1:0] v;
    bit issue_hs;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n) begin
        issue_hs = lif.gbm_valid_out && lif.gbm_ready_in;
        chk("z_ready", z_ready, issue_hs);
        if (lif.gbm_valid_out) chk("valid_needs_z", z_valid, 1);
        if (z_ready) n_zr++;
        if (issue_hs) begin
          chk("barrier", ret_cnt >= m_istep * NP, 1);
          chk("gbm_s", lif.gbm_s, (m_istep == 0) ? cur_s0 : m_store[m_ipath]);
          chk("gbm_z", lif.gbm_z, z);
          chk("gbm_r", lif.gbm_r, cur_r);
          chk("gbm_sigma", lif.gbm_sigma, cur_sig);
          chk("gbm_dt", lif.gbm_dt, cur_dt);
          lane_q.push_back(lif.gbm_s + (add_one ? ONE : '0));
          last_iss[m_ipath] = lif.gbm_s;
          n_issue++;
          m_ipath++;
          if (m_ipath == NP) begin m_ipath = 0; m_istep++; end
        end
        if (lif.gbm_valid_in && lif.gbm_ready_out && !force_spur && lane_q.size() > 0) begin
          v = lane_q.pop_front();
`ifdef GBM_SCHED_STREAM_EN
          chk("out_valid", out_valid, 1);
          chk("out_s", out_s, v);
          chk("out_path", out_path, m_rpath);
          chk("out_step", out_step, m_rstep);
`else
          chk("out_valid_tied", out_valid, 0);
`endif
          m_store[m_rpath] = v;
          last_out[m_rpath] = v;
          ret_cnt++;
          last_ret_cyc = cyc;
          m_rpath++;
          if (m_rpath == NP) begin m_rpath = 0; m_rstep++; end
        end
        if (done) begin
          done_cnt++;
          chk("done_busy", busy, 1);
          chk("done_latency", cyc - last_ret_cyc, 1);
        end
      end
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_z_ready"}, z_ready, 0);
    chk({tag, "_valid_out"}, lif.gbm_valid_out, 0);
    chk({tag, "_fields"}, {lif.gbm_z, lif.gbm_s, lif.gbm_r, lif.gbm_sigma}, 0);
    chk({tag, "_dt"}, lif.gbm_dt, 0);
    chk({tag, "_out"}, {out_valid, out_s, out_path, out_step}, 0);
    chk({tag, "_status"}, {busy, done, err_unexpected}, 0);
`ifdef GBM_SCHED_STREAM_EN
    chk({tag, "_ready_out"}, lif.gbm_ready_out, 0);
`else
    chk({tag, "_ready_out"}, lif.gbm_ready_out, 1);
`endif
  endtask

  task automatic clear_model();
    lane_q.delete();
    m_ipath = 0; m_istep = 0; m_rpath = 0; m_rstep = 0;
    n_issue = 0; n_zr = 0; ret_cnt = 0; done_cnt = 0; last_ret_cyc = 0;
  endtask

  task automatic launch(input logic [W-1:0] s0, input int idx);
    cur_s0 = s0;
    cur_r = 32'h0000_0C00 + idx;
    cur_sig = 32'h0000_3000 + idx;
    cur_dt = 32'h0000_0148 + idx;
    cfg_s0 = cur_s0; cfg_r = cur_r; cfg_sigma = cur_sig; cfg_dt = cur_dt;
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    cfg_s0 = ~cur_s0; cfg_r = ~cur_r; cfg_sigma = ~cur_sig; cfg_dt = ~cur_dt;
  endtask

  task automatic stall20();
    out_hold = 1'b1;
    out_ready = 1'b0;
`ifdef GBM_SCHED_STREAM_EN
    begin
      bit seen = 1'b0;
      for (int j = 0; j < 10 && !seen; j++) begin
        @(negedge clk);
        seen = out_valid;
      end
      chk("stall_seen", seen, 1);
      repeat (20) begin
        @(negedge clk);
        chk("stall_valid", out_valid, 1);
        chk("stall_out_s", out_s, (lane_q.size() > 0) ? lane_q[0] : '0);
        chk("stall_tags", {out_path, out_step}, {m_rpath[1:0], m_rstep[1:0]});
        chk("stall_ready", lif.gbm_ready_out, 0);
      end
    end
`else
    repeat (20) begin
      @(negedge clk);
      chk("stall_ready_tied", lif.gbm_ready_out, 1);
      chk("stall_out_valid", out_valid, 0);
    end
`endif
    @(posedge clk); #2;
    out_hold = 1'b0;
  endtask

  task automatic run_one(input run_vec_t v, input int idx);
    bit ok = 1'b0;
    clear_model();
    add_one = v.add_one; zgap = v.zgap; rgap = v.rgap; ogap = v.ogap; lane_en = 1'b1;
    launch(v.s0, idx);
    @(negedge clk);
    chk("start_busy", busy, 1);
    chk("start_first_valid", lif.gbm_valid_out, z_valid);
    for (int k = 0; k < 2000; k++) begin
      @(posedge clk); #2;
      start = (v.poke && k == 3);
      if (v.stall && k == 2) stall20();
      if (done_cnt > 0 && !busy) begin ok = 1'b1; break; end
    end
    start = 1'b0;
    chk("run_completes", ok, 1);
    @(negedge clk);
    chk("after_done_low", {busy, done}, 0);
    chk("done_count", done_cnt, 1);
    chk("issue_count", n_issue, NP * NS);
    chk("zready_count", n_zr, NP * NS);
    chk("retire_count", ret_cnt, NP * NS);
    for (int p = 0; p < NP; p++) begin
      chk("last_issue_s", last_iss[p], v.exp_iss);
`ifdef GBM_SCHED_STREAM_EN
      chk("final_out_s", last_out[p], v.exp_final);
`endif
    end
    zgap = 1'b0; rgap = 1'b0; ogap = 1'b0;
    @(posedge clk); #2;
  endtask

  task automatic drain_reset();
    bit ok = 1'b0;
    clear_model();
    add_one = 1'b1; lane_en = 1'b1;
    launch(32'h0003_0000, 7);
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #2;
      if (n_issue >= 2 * NP - 1) begin ok = 1'b1; break; end
    end
    lane_en = 1'b0;
    chk("drain_reach", ok, 1);
    repeat (4) begin @(posedge clk); #2; end
    @(negedge clk);
    chk("drain_issues", n_issue, 2 * NP);
    chk("drain_hold_valid", lif.gbm_valid_out, 0);
    chk("drain_busy", busy, 1);
    chk("drain_step", out_step, 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_zero("midrst");
    lane_q.delete();
    lane_en = 1'b1;
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #2;
  endtask

  task automatic spurious();
    force_spur = 1'b1;
    @(negedge clk);
    chk("spur_ready", lif.gbm_ready_out, 1);
    chk("spur_out_valid", out_valid, 0);
    chk("spur_err_before", err_unexpected, 0);
    @(posedge clk); #2;
    force_spur = 1'b0;
    @(negedge clk);
    chk("spur_err_set", err_unexpected, 1);
    chk("spur_idle", busy, 0);
    repeat (3) begin @(posedge clk); #2; end
    @(negedge clk);
    chk("spur_err_sticky", err_unexpected, 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    chk("spur_err_cleared", err_unexpected, 0);
    @(posedge clk); #2;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0;
    cfg_s0 = '0; cfg_r = '0; cfg_sigma = '0; cfg_dt = '0;
    //           s0            add zg rg og pk st  exp_iss        exp_final
    vec[0] = '{32'h0005_0000, 0, 0, 0, 0, 0, 0, 32'h0005_0000, 32'h0005_0000};
    vec[1] = '{32'h0002_8000, 1, 0, 0, 0, 0, 0, 32'h0004_8000, 32'h0005_8000};
    vec[2] = '{32'h0001_0000, 0, 1, 1, 0, 0, 0, 32'h0001_0000, 32'h0001_0000};
    vec[3] = '{32'h0010_8000, 1, 1, 0, 1, 1, 0, 32'h0012_8000, 32'h0013_8000};
    vec[4] = '{32'h0000_4000, 1, 0, 0, 0, 0, 1, 32'h0002_4000, 32'h0003_4000};
    repeat (3) @(posedge clk);
    #2;
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #2;
    for (int i = 0; i < 5; i++) run_one(vec[i], i);
    drain_reset();
    spurious();
    run_one(vec[1], 5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
